// File: rtl/layeriomem_bank_sched.sv
// Ping-pong bank scheduler: fetches one rd/wr instruction pair per layer, counts lane beats, swaps banks when both totals are met.
// FIFO pop is combinational in FETCH; completion pulses one cycle after the last write beat; upstream throttles on rd_en/rd_remaining.
module layeriomem_bank_sched #(
  parameter int unsigned       CLKDIV      = 4,
  parameter int unsigned       DIGIT_W     = 16,
  parameter int unsigned       ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] BANK_OFFSET = 16'h4000,
  parameter int unsigned       LAYER_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LAYER_W-1:0] num_layers,
  input  logic               rd_instruc_valid,
  input  logic [DIGIT_W-1:0] rd_instruc_total,
  output logic               rd_instruc_rdreq,
  input  logic               wr_instruc_valid,
  input  logic [DIGIT_W-1:0] wr_instruc_total,
  output logic               wr_instruc_rdreq,
  input  logic [CLKDIV-1:0]  rd_beats,
  input  logic [CLKDIV-1:0]  wr_beats,
  output logic               rd_en,
  output logic [DIGIT_W-1:0] rd_remaining,
  output logic [ADDR_W-1:0]  rd_offset,
  output logic [ADDR_W-1:0]  wr_offset,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               wrote_layerio_layer,
  output logic               wrote_inference,
  output logic               error
);

  localparam int unsigned CW = DIGIT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RUN,
    S_DRAIN,
    S_SWAP
  } state_t;

  state_t             state_q;
  logic               bank_q;
  logic [LAYER_W-1:0] layer_q;
  logic [LAYER_W-1:0] last_q;
  logic [DIGIT_W-1:0] rd_total_q;
  logic [DIGIT_W-1:0] wr_total_q;
  logic [CW-1:0]      rd_cnt_q;
  logic [CW-1:0]      wr_cnt_q;
  logic               rd_en_q;
  logic               busy_q;
  logic               layer_pulse_q;
  logic               inf_pulse_q;
  logic               error_q;
  logic [ADDR_W-1:0]  rd_off_q;
  logic [ADDR_W-1:0]  wr_off_q;

  logic [CW-1:0]      rd_cnt_d;
  logic [CW-1:0]      wr_cnt_d;
  logic [CW-1:0]      rd_sum;
  logic [CW-1:0]      wr_sum;
  logic [CW-1:0]      rd_tot_ext;
  logic [CW-1:0]      wr_tot_ext;
  logic               pop;
  logic               wr_phase;
  logic               rd_done_d;
  logic               wr_done_d;
  logic               err_d;

  function automatic logic [CW-1:0] popcnt(input logic [CLKDIV-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < CLKDIV; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  assign pop              = (state_q == S_FETCH) && rd_instruc_valid && wr_instruc_valid;
  assign rd_instruc_rdreq = pop;
  assign wr_instruc_rdreq = pop;
  assign wr_phase         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign rd_tot_ext       = {1'b0, rd_total_q};
  assign wr_tot_ext       = {1'b0, wr_total_q};

  // Counts saturate at the total; an overshoot is a protocol error, not a wrap.
  always_comb begin
    rd_sum    = rd_cnt_q + popcnt(rd_beats);
    wr_sum    = wr_cnt_q + popcnt(wr_beats);
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_d     = ((|rd_beats) && !rd_en_q) || ((|wr_beats) && !wr_phase);
    if (state_q == S_RUN) begin
      if (rd_sum > rd_tot_ext) begin
        rd_cnt_d = rd_tot_ext;
        err_d    = 1'b1;
      end else begin
        rd_cnt_d = rd_sum;
      end
    end
    if (wr_phase) begin
      if (wr_sum > wr_tot_ext) begin
        wr_cnt_d = wr_tot_ext;
        err_d    = 1'b1;
      end else begin
        wr_cnt_d = wr_sum;
      end
    end
    rd_done_d = (rd_cnt_d == rd_tot_ext);
    wr_done_d = (wr_cnt_d == wr_tot_ext);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      bank_q        <= 1'b0;
      layer_q       <= '0;
      last_q        <= '0;
      rd_total_q    <= '0;
      wr_total_q    <= '0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      rd_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      layer_pulse_q <= 1'b0;
      inf_pulse_q   <= 1'b0;
      error_q       <= 1'b0;
      rd_off_q      <= '0;
      wr_off_q      <= '0;
    end else begin
      error_q       <= error_q || err_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      layer_pulse_q <= 1'b0;
      inf_pulse_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_FETCH;
            busy_q   <= 1'b1;
            layer_q  <= '0;
            bank_q   <= 1'b0;
            rd_off_q <= '0;
            wr_off_q <= BANK_OFFSET;
            last_q   <= (num_layers == '0) ? '0 : num_layers - LAYER_W'(1);
          end
        end
        S_FETCH: begin
          if (pop) begin
            rd_total_q <= rd_instruc_total;
            wr_total_q <= wr_instruc_total;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            rd_en_q    <= |rd_instruc_total;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          // rd_en only stays high while beats are still owed, so it drops the cycle after the last read.
          if (rd_done_d) begin
            rd_en_q <= 1'b0;
            if (wr_done_d) begin
              state_q       <= S_SWAP;
              layer_pulse_q <= 1'b1;
              inf_pulse_q   <= (layer_q == last_q);
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (wr_done_d) begin
            state_q       <= S_SWAP;
            layer_pulse_q <= 1'b1;
            inf_pulse_q   <= (layer_q == last_q);
          end
        end
        S_SWAP: begin
          bank_q   <= ~bank_q;
          rd_off_q <= bank_q ? '0 : BANK_OFFSET;
          wr_off_q <= bank_q ? BANK_OFFSET : '0;
          if (layer_q == last_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            layer_q <= layer_q + LAYER_W'(1);
            state_q <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_remaining        = (rd_tot_ext > rd_cnt_q) ? (rd_total_q - rd_cnt_q[DIGIT_W-1:0]) : '0;
  assign rd_en               = rd_en_q;
  assign rd_offset           = rd_off_q;
  assign wr_offset           = wr_off_q;
  assign layer_idx           = layer_q;
  assign busy                = busy_q;
  assign wrote_layerio_layer = layer_pulse_q;
  assign wrote_inference     = inf_pulse_q;
  assign error               = error_q;

endmodule

// File: tb/tb_layeriomem_bank_sched.sv
// Bench for layeriomem_bank_sched: directed layer sequences checked against a spec-level model every cycle.
module tb_layeriomem_bank_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_layers = 8'd1;
  logic        rd_instruc_valid = 1'b0;
  logic [15:0] rd_instruc_total = '0;
  logic        rd_instruc_rdreq;
  logic        wr_instruc_valid = 1'b0;
  logic [15:0] wr_instruc_total = '0;
  logic        wr_instruc_rdreq;
  logic [3:0]  rd_beats = '0;
  logic [3:0]  wr_beats = '0;
  logic        rd_en;
  logic [15:0] rd_remaining;
  logic [15:0] rd_offset;
  logic [15:0] wr_offset;
  logic [7:0]  layer_idx;
  logic        busy;
  logic        wrote_layerio_layer;
  logic        wrote_inference;
  logic        error;

  always #5 clk = ~clk;

  layeriomem_bank_sched dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .num_layers         (num_layers),
    .rd_instruc_valid   (rd_instruc_valid),
    .rd_instruc_total   (rd_instruc_total),
    .rd_instruc_rdreq   (rd_instruc_rdreq),
    .wr_instruc_valid   (wr_instruc_valid),
    .wr_instruc_total   (wr_instruc_total),
    .wr_instruc_rdreq   (wr_instruc_rdreq),
    .rd_beats           (rd_beats),
    .wr_beats           (wr_beats),
    .rd_en              (rd_en),
    .rd_remaining       (rd_remaining),
    .rd_offset          (rd_offset),
    .wr_offset          (wr_offset),
    .layer_idx          (layer_idx),
    .busy               (busy),
    .wrote_layerio_layer(wrote_layerio_layer),
    .wrote_inference    (wrote_inference),
    .error              (error)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Phases: 0 idle, 1 fetch, 2 run, 3 drain, 4 swap.
  int m_mode, m_layer, m_last, m_bank, m_rdtot, m_wrtot, m_rdcnt, m_wrcnt, m_rdoff, m_wroff;
  bit m_rden, m_busy, m_lp, m_ip, m_err;

  task automatic model_reset();
    m_mode = 0; m_layer = 0; m_last = 0; m_bank = 0;
    m_rdtot = 0; m_wrtot = 0; m_rdcnt = 0; m_wrcnt = 0;
    m_rdoff = 0; m_wroff = 0;
    m_rden = 0; m_busy = 0; m_lp = 0; m_ip = 0; m_err = 0;
  endtask

  task automatic model_step();
    int rb, wb, nm;
    rb = $countones(rd_beats);
    wb = $countones(wr_beats);
    if (rb > 0 && !m_rden) m_err = 1;
    if (wb > 0 && !(m_mode == 2 || m_mode == 3)) m_err = 1;
    nm = m_mode;
    case (m_mode)
      0: if (start) begin
        nm = 1; m_layer = 0; m_bank = 0; m_rdoff = 0; m_wroff = 'h4000;
        m_last = (num_layers == 0) ? 0 : int'(num_layers) - 1;
      end
      1: if (rd_instruc_valid && wr_instruc_valid) begin
        m_rdtot = rd_instruc_total; m_wrtot = wr_instruc_total;
        m_rdcnt = 0; m_wrcnt = 0; nm = 2;
      end
      2, 3: begin
        if (m_mode == 2) m_rdcnt += rb;
        m_wrcnt += wb;
        if (m_rdcnt > m_rdtot) begin m_rdcnt = m_rdtot; m_err = 1; end
        if (m_wrcnt > m_wrtot) begin m_wrcnt = m_wrtot; m_err = 1; end
        if (m_rdcnt == m_rdtot && m_wrcnt == m_wrtot) nm = 4;
        else if (m_rdcnt == m_rdtot) nm = 3;
      end
      4: begin
        m_bank = 1 - m_bank;
        m_rdoff = m_bank ? 'h4000 : 0;
        m_wroff = m_bank ? 0 : 'h4000;
        if (m_layer == m_last) nm = 0;
        else begin m_layer++; nm = 1; end
      end
      default: nm = 0;
    endcase
    m_lp = (nm == 4);
    m_ip = (nm == 4) && (m_layer == m_last);
    m_rden = (nm == 2) && (m_rdtot > m_rdcnt);
    m_busy = (nm != 0);
    m_mode = nm;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  always @(negedge clk) begin
    chk("m_busy", busy, m_busy);
    chk("m_rd_en", rd_en, m_rden);
    chk("m_rd_remaining", rd_remaining, (m_rdtot > m_rdcnt) ? m_rdtot - m_rdcnt : 0);
    chk("m_rd_offset", rd_offset, m_rdoff);
    chk("m_wr_offset", wr_offset, m_wroff);
    chk("m_layer_idx", layer_idx, m_layer);
    chk("m_layer_pulse", wrote_layerio_layer, m_lp);
    chk("m_inf_pulse", wrote_inference, m_ip);
    chk("m_error", error, m_err);
    chk("m_rd_rdreq", rd_instruc_rdreq, (m_mode == 1) && rd_instruc_valid && wr_instruc_valid);
    chk("m_wr_rdreq", wr_instruc_rdreq, (m_mode == 1) && rd_instruc_valid && wr_instruc_valid);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [15:0] rt, input logic [15:0] wt);
    rd_instruc_total = rt; wr_instruc_total = wt;
    rd_instruc_valid = 1'b1; wr_instruc_valid = 1'b1;
  endtask

  task automatic beats(input logic [3:0] rb, input logic [3:0] wb);
    rd_beats = rb; wr_beats = wb;
  endtask

  logic [15:0] exp_rd_off [3] = '{16'h0000, 16'h4000, 16'h0000};
  logic [15:0] exp_wr_off [3] = '{16'h4000, 16'h0000, 16'h4000};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_offset", wr_offset, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    tick();

    // Single layer, reads ahead of writes.
    num_layers = 8'd1; instr(16'd10, 16'd6);
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_pop", rd_instruc_rdreq, 1);
    tick(); rd_instruc_valid = 0; wr_instruc_valid = 0;
    chk("t1_rd_en0", rd_en, 1);
    chk("t1_rem10", rd_remaining, 10);
    beats(4'b1111, 4'b0001); tick();
    chk("t1_rem6", rd_remaining, 6);
    beats(4'b1111, 4'b0001); tick();
    chk("t1_rem2", rd_remaining, 2);
    chk("t1_rd_en2", rd_en, 1);
    beats(4'b0011, 4'b0001); tick();
    chk("t1_rem0", rd_remaining, 0);
    chk("t1_rd_en_off", rd_en, 0);
    beats(4'b0000, 4'b0011); tick();
    chk("t1_no_pulse", wrote_layerio_layer, 0);
    beats(4'b0000, 4'b0001); tick();
    chk("t1_layer_pulse", wrote_layerio_layer, 1);
    chk("t1_inf_pulse", wrote_inference, 1);
    chk("t1_busy_swap", busy, 1);
    beats(4'b0000, 4'b0000); tick();
    chk("t1_busy_low", busy, 0);
    chk("t1_pulse_low", wrote_layerio_layer, 0);

    // Three layers, reads and writes finishing together every layer.
    num_layers = 8'd3; instr(16'd4, 16'd4);
    start = 1'b1; tick(); start = 1'b0;
    for (int l = 0; l < 3; l++) begin
      chk("t2_pop", rd_instruc_rdreq, 1);
      tick();
      chk("t2_layer", layer_idx, l);
      chk("t2_rd_off", rd_offset, exp_rd_off[l]);
      chk("t2_wr_off", wr_offset, exp_wr_off[l]);
      chk("t2_rem", rd_remaining, 4);
      beats(4'b1111, 4'b1111); tick();
      chk("t2_layer_pulse", wrote_layerio_layer, 1);
      chk("t2_inf_pulse", wrote_inference, l == 2);
      beats(4'b0000, 4'b0000); tick();
      chk("t2_busy_after", busy, l < 2);
    end
    rd_instruc_valid = 0; wr_instruc_valid = 0;

    // Zero totals, num_layers of 0 acts as a single layer.
    num_layers = 8'd0; instr(16'd0, 16'd0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); rd_instruc_valid = 0; wr_instruc_valid = 0;
    chk("t3_rd_en_run", rd_en, 0);
    chk("t3_no_pulse", wrote_layerio_layer, 0);
    tick();
    chk("t3_layer_pulse", wrote_layerio_layer, 1);
    chk("t3_inf_pulse", wrote_inference, 1);
    tick();
    chk("t3_busy_low", busy, 0);
    chk("t3_no_error", error, 0);

    // Write overshoot: 5 beats against a total of 4 clamps and completes.
    num_layers = 8'd1; instr(16'd0, 16'd4);
    start = 1'b1; tick(); start = 1'b0;
    tick(); rd_instruc_valid = 0; wr_instruc_valid = 0;
    beats(4'b0000, 4'b0011); tick();
    chk("t4_error_clean", error, 0);
    beats(4'b0000, 4'b0111); tick();
    chk("t4_clamp_done", wrote_layerio_layer, 1);
    chk("t4_error_set", error, 1);
    beats(4'b0000, 4'b0000); tick();
    chk("t4_error_sticky", error, 1);
    reset = 1'b1; tick();
    chk("t4_error_reset", error, 0);
    reset = 1'b0;
    beats(4'b0001, 4'b0000); tick();
    beats(4'b0000, 4'b0000);
    chk("t4_rd_err", error, 1);
    tick();
    chk("t4_rd_err_sticky", error, 1);

    // Reset in the middle of layer 1, then a clean restart.
    reset = 1'b1; tick(); reset = 1'b0;
    num_layers = 8'd2; instr(16'd8, 16'd8);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    beats(4'b1111, 4'b1111); tick();
    beats(4'b1111, 4'b1111); tick();
    beats(4'b0000, 4'b0000); tick();
    tick();
    chk("t5_layer1", layer_idx, 1);
    chk("t5_rd_off1", rd_offset, 16'h4000);
    beats(4'b1111, 4'b0000); start = 1'b1; tick();
    beats(4'b0001, 4'b0000); tick();
    start = 1'b0; beats(4'b0000, 4'b0000);
    chk("t5_rem3", rd_remaining, 3);
    chk("t5_start_ignored", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_busy", busy, 0);
    chk("t5_async_rd_off", rd_offset, 0);
    chk("t5_async_layer", layer_idx, 0);
    chk("t5_async_rem", rd_remaining, 0);
    chk("t5_async_error", error, 0);
    tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_restart_busy", busy, 1);
    chk("t5_restart_wr_off", wr_offset, 16'h4000);
    tick();
    chk("t5_restart_layer", layer_idx, 0);
    chk("t5_restart_rd_off", rd_offset, 0);
    chk("t5_restart_rem", rd_remaining, 8);
    for (int l = 0; l < 2; l++) begin
      beats(4'b1111, 4'b1111); tick();
      beats(4'b1111, 4'b1111); tick();
      chk("t5_layer_pulse", wrote_layerio_layer, 1);
      chk("t5_inf_pulse", wrote_inference, l == 1);
      beats(4'b0000, 4'b0000); tick();
      if (l == 0) tick();
    end
    chk("t5_done_busy", busy, 0);
    rd_instruc_valid = 0; wr_instruc_valid = 0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
